// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback port arbiter: default widths, the hard-wired
// zero register, requester indices and the round-robin pointer advance helper.
package wb_port_arbiter_pkg;

    localparam int NREQ_DEF = 2;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;

    localparam int REG_ZERO = 0;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MD   = 1;

    // Pointer moves to the requester just after the one that was served.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus: requester valid/ready, register-file write port and scoreboard.
// master = writeback sources / decode side, slave = the arbiter.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;

    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;

    logic                 sb_set;
    logic [AW-1:0]        sb_set_addr;
    logic [(2**AW)-1:0]   sb_busy;

    modport master (
        output req_valid, req_addr, req_data, sb_set, sb_set_addr,
        input  req_ready, rf_we, rf_waddr, rf_wdata, sb_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, sb_set, sb_set_addr,
        output req_ready, rf_we, rf_waddr, rf_wdata, sb_busy
    );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans the valid vector from i_ptr upward with
// wrap-around and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic w_found;
    int   w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_valid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = IW'(w_cand);
                w_found         = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// write stage and a busy scoreboard of destinations with long-latency writes pending.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                clk,
    input  logic                clr_n,
    wb_port_arbiter_if.slave    bus
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2 ** AW;

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_grant;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_addr_nz;

    logic            r_rf_we;
    logic [AW-1:0]   r_rf_waddr;
    logic [DW-1:0]   r_rf_wdata;

    logic [NREG-1:0] r_sb_busy;
    logic [NREG-1:0] w_sb_set;
    logic [NREG-1:0] w_sb_clr;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_xfer)
    );

    // Ready is masked by reset so requesters never see a grant while clr_n is low.
    assign bus.req_ready = w_grant & {NREQ{clr_n}};

    always_comb begin
        w_addr = bus.req_addr[int'(w_idx)*AW +: AW];
        w_data = bus.req_data[int'(w_idx)*DW +: DW];
    end

    assign w_addr_nz = (w_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ptr      <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && w_addr_nz;
            if (w_xfer) begin
                r_ptr      <= IW'(next_idx(int'(w_idx), NREQ));
                r_rf_waddr <= w_addr;
                r_rf_wdata <= w_data;
            end
        end
    end

    // Per-register set/clear strobes; register zero can never become busy.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        if (gi == REG_ZERO) begin : g_zero
            assign w_sb_set[gi] = 1'b0;
            assign w_sb_clr[gi] = 1'b0;
        end else begin : g_reg
            assign w_sb_set[gi] = bus.sb_set && (bus.sb_set_addr == AW'(gi));
            assign w_sb_clr[gi] = w_xfer && (w_addr == AW'(gi));
        end
    end

    // Clear is applied first so a coincident set on the same register wins.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sb_busy <= '0;
        end else begin
            r_sb_busy <= (r_sb_busy & ~w_sb_clr) | w_sb_set;
        end
    end

    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;
    assign bus.sb_busy  = r_sb_busy;

endmodule
